instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
- Encode side of the immediate path. Takes decoded instruction fields plus a 32-bit immediate and packs them into an I-type or S-type RV32 instruction word.
- Writes each packed word sequentially into instruction memory through a valid/ack write port.
- Used as the boot/program loader ahead of the single-cycle core.
- Performs the exact inverse of the core's immediate extraction: imm_src 00 = I-type, 01 = S-type.

Parameters:
- DEPTH_LOG2, 6: address width of instruction memory in words; capacity 2**DEPTH_LOG2.
- BASE_ADDR, 0: word address of the first write after reset or clear.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- clear  in  1  synchronous restart of the write pointer
- in_valid  in  1  field bundle valid
- in_ready  out  1  packer can accept a bundle
- imm_src  in  2  00 I-type, 01 S-type, 10/11 illegal
- imm  in  32  signed immediate
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- rd  in  5  I-type instr[11:7]
- rs1  in  5  instr[19:15]
- rs2  in  5  S-type instr[24:20]
- mem_we  out  1  write request (valid)
- mem_ack  in  1  memory accepted the write
- mem_addr  out  DEPTH_LOG2  word address
- mem_wdata  out  32  packed instruction
- wr_count  out  DEPTH_LOG2+1  words written since reset/clear
- full  out  1  capacity reached
- err_range  out  1  one-cycle pulse: imm not representable in 12 bits
- err_src  out  1  one-cycle pulse: imm_src illegal

Behaviour:
- Reset values (rst_n low): state IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, wr_count=0, full=0, err_range=0, err_src=0.
- in_ready is 1 only in IDLE.
- States: IDLE, WRITE, FULL.
- IDLE, on in_valid && in_ready:
  - Legal bundle: pack, register into mem_wdata, go to WRITE. mem_we is high the next cycle, so latency from accept to write request is 1 cycle.
  - imm_src = 10/11: handshake completes, bundle dropped, err_src pulses for exactly 1 cycle, stay in IDLE.
  - imm[31:11] not all equal: handshake completes, bundle dropped, err_range pulses for 1 cycle, stay in IDLE. When both errors apply, only err_src pulses.
- Packing:
  - I-type: {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Unused field inputs are ignored.
- WRITE: mem_we=1; mem_addr and mem_wdata held stable until mem_ack.
  - On mem_ack: mem_we drops and wr_count increments.
  - If mem_addr == BASE_ADDR + 2**DEPTH_LOG2 - 1: go to FULL with full=1 and mem_addr held.
  - Otherwise: mem_addr increments and state returns to IDLE.
  - mem_addr wraps modulo 2**DEPTH_LOG2 and is never reached past capacity.
- FULL: in_ready=0; further bundles are not accepted. Leaves only via clear or reset.
- clear: highest synchronous priority in every state. Aborts a pending write (mem_we=0 next cycle, ack in that cycle ignored), mem_addr=BASE_ADDR, wr_count=0, full=0, state IDLE.
- Reset mid-write: asynchronous; mem_we drops immediately and no partial state is retained.

Optional Feature:
- ROUNDTRIP_CHECK_EN defined:
  - Adds output err_roundtrip, which is sticky until clear or reset.
  - Each packed word is re-decoded by an internal imm extractor (inverse of the packing).
  - The extracted value is compared with imm at the accept edge; a mismatch sets err_roundtrip.
  - The write still proceeds.
- Undefined: the port is absent and no checker logic is generated.

Decomposition:
- Shared package riscv_pkg:
  - IMM_I=2'b00, IMM_S=2'b01.
  - OPC_OPIMM=7'b0010011, OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011.
  - State enum for IDLE/WRITE/FULL.
- Sub-module imm_pack: purely combinational field packer, outputs the word plus a legal flag. The FSM, pointer and handshake stay in instr_packer.

Test Plan:
- I-type addi x1,x0,-1: imm=0xFFFFFFFF, opcode=0010011, funct3=000, rd=1, rs1=0 -> mem_wdata=0xFFF00093 at mem_addr 0, mem_we high 1 cycle after accept, wr_count=1 after ack.
- S-type sw x2,8(x0): imm=8, opcode=0100011, funct3=010, rs1=0, rs2=2 -> mem_wdata=0x00202423 at mem_addr 1.
- Errors:
  - imm=0x00000800, imm_src=00 -> err_range pulses 1 cycle, no mem_we, mem_addr unchanged.
  - imm_src=11 -> err_src only.
- Backpressure: mem_ack held low 3 cycles -> mem_we, mem_addr and mem_wdata stable, in_ready=0 throughout; ack in cycle 4 -> back to IDLE.
- Full and wrap: DEPTH_LOG2=2, 4 legal writes -> full=1, in_ready=0, wr_count=4, mem_addr=3; then clear -> mem_addr=0, full=0, wr_count=0.
- Abort cases:
  - Assert rst_n low while mem_we=1 -> mem_we=0 with no clock edge, all outputs at reset values.
  - clear during WRITE with a simultaneous mem_ack -> wr_count stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants, packer FSM states and the immediate extractor
// used to re-decode packed words (the inverse of imm_pack).
package riscv_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Same extraction the core performs on a fetched word.
    function automatic logic [31:0] extract_imm(input logic [1:0] src, input logic [31:0] word);
        logic [31:0] val;
        if (src == IMM_S) val = {{20{word[31]}}, word[31:25], word[11:7]};
        else              val = {{20{word[31]}}, word[31:20]};
        return val;
    endfunction

endpackage

// File: rtl/instr_packer_imm_pack.sv
// Combinational field packer: builds an I- or S-type word and flags whether the
// bundle is encodable (legal imm_src and imm fits in a signed 12-bit field).
module imm_pack
    import riscv_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic        legal
);

    logic range_ok;

    always_comb begin
        // Representable iff the top 21 bits are a pure sign extension.
        range_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
        word     = '0;
        legal    = 1'b0;
        case (imm_src)
            IMM_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = range_ok;
            end
            IMM_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = range_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// Boot loader: packs instruction field bundles and writes them sequentially into
// instruction memory. Define ROUNDTRIP_CHECK_EN to add the sticky re-decode checker.
module instr_packer
    import riscv_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            imm_src,
    input  logic [31:0]           imm,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [DEPTH_LOG2:0]   wr_count,
    output logic                  full,
    output logic                  err_range,
    output logic                  err_src,
`ifdef ROUNDTRIP_CHECK_EN
    output logic                  err_roundtrip,
`endif
    output logic [1:0]            dbg_state
);

    // Both handshakes: a transfer happens on a rising edge where valid and
    // ready/ack are high together; the source holds its payload until then.
    localparam logic [DEPTH_LOG2-1:0] BASE_A = DEPTH_LOG2'(BASE_ADDR);
    localparam logic [DEPTH_LOG2-1:0] LAST_A = BASE_A - DEPTH_LOG2'(1);

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  err_range_q, err_range_d;
    logic                  err_src_q, err_src_d;
    logic [31:0]           packed_word;
    logic                  packed_legal;

    imm_pack u_imm_pack (
        .imm_src (imm_src),
        .imm     (imm),
        .opcode  (opcode),
        .funct3  (funct3),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .word    (packed_word),
        .legal   (packed_legal)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        err_range_d = 1'b0;
        err_src_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            addr_d  = BASE_A;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (imm_src[1])         err_src_d   = 1'b1;
                        else if (!packed_legal) err_range_d = 1'b1;
                        else begin
                            wdata_d = packed_word;
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        count_d = count_q + 1'b1;
                        if (addr_q == LAST_A) state_d = ST_FULL;
                        else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= BASE_A;
            wdata_q     <= '0;
            count_q     <= '0;
            err_range_q <= 1'b0;
            err_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            err_range_q <= err_range_d;
            err_src_q   <= err_src_d;
        end
    end

`ifdef ROUNDTRIP_CHECK_EN
    logic rt_q, rt_d;

    always_comb begin
        rt_d = rt_q;
        if (clear) rt_d = 1'b0;
        else if (state_q == ST_IDLE && in_valid && packed_legal &&
                 extract_imm(imm_src, packed_word) != imm)
            rt_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rt_q <= 1'b0;
        else        rt_q <= rt_d;
    end

    assign err_roundtrip = rt_q;
`endif

    // mem_we and full decode straight from state so reset drops them at once.
    assign in_ready  = (state_q == ST_IDLE);
    assign mem_we    = (state_q == ST_WRITE);
    assign full      = (state_q == ST_FULL);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wr_count  = count_q;
    assign err_range = err_range_q;
    assign err_src   = err_src_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer (DEPTH_LOG2=2, BASE_ADDR=0) against a
// behavioural encoder model built from shifts and signed range arithmetic.
module tb_instr_packer;

    localparam int D     = 2;
    localparam int DEPTH = 1 << D;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [1:0]    imm_src;
    logic [31:0]   imm;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd, rs1, rs2;
    logic          mem_we, mem_ack;
    logic [D-1:0]  mem_addr;
    logic [31:0]   mem_wdata;
    logic [D:0]    wr_count;
    logic          full, err_range, err_src;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    instr_packer #(.DEPTH_LOG2(D), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .imm(imm), .opcode(opcode), .funct3(funct3), .rd(rd),
        .rs1(rs1), .rs2(rs2), .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wr_count(wr_count), .full(full), .err_range(err_range),
        .err_src(err_src), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_pack(input logic [1:0] src, input logic [31:0] v,
                                             input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [4:0] d_rd, input logic [4:0] s1,
                                             input logic [4:0] s2);
        logic [31:0] lo12;
        lo12 = v & 32'hFFF;
        if (src == 2'b00)
            return (lo12 << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d_rd) << 7) | 32'(opc);
        return ((lo12 >> 5) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
               | ((lo12 % 32) << 7) | 32'(opc);
    endfunction

    function automatic bit ref_fits12(input logic [31:0] v);
        int s;
        s = $signed(v);
        return (s >= -2048) && (s <= 2047);
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_bundle(input logic [1:0] src, input logic [31:0] v, input logic [6:0] opc,
                                input logic [2:0] f3, input logic [4:0] d_rd,
                                input logic [4:0] s1, input logic [4:0] s2);
        imm_src = src; imm = v; opcode = opc; funct3 = f3; rd = d_rd; rs1 = s1; rs2 = s2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pulse_ack();
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr got=%0d exp=0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        n_tests++; if (wr_count !== '0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", wr_count); end
        n_tests++; if ({full, err_range, err_src} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%b exp=000", {full, err_range, err_src}); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_itype();
        logic [31:0] exp_w;
        exp_w = ref_pack(2'b00, 32'hFFFF_FFFF, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0);
        n_tests++; if (exp_w !== 32'hFFF0_0093) begin n_fail++; $display("FAIL itype_model got=%h exp=fff00093", exp_w); end
        drive_bundle(2'b00, 32'hFFFF_FFFF, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0);
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL itype_latency mem_we got=%b exp=1", mem_we); end
        n_tests++; if (mem_wdata !== 32'hFFF0_0093) begin n_fail++; $display("FAIL itype_wdata got=%h exp=fff00093", mem_wdata); end
        n_tests++; if (mem_addr !== 2'd0) begin n_fail++; $display("FAIL itype_addr got=%0d exp=0", mem_addr); end
        pulse_ack();
        n_tests++; if (wr_count !== 3'd1) begin n_fail++; $display("FAIL itype_count got=%0d exp=1", wr_count); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL itype_we_drop got=%b exp=0", mem_we); end
    endtask

    task automatic test_stype();
        drive_bundle(2'b01, 32'd8, 7'b0100011, 3'b010, 5'd31, 5'd0, 5'd2);
        n_tests++; if (mem_wdata !== 32'h0020_2423) begin n_fail++; $display("FAIL stype_wdata got=%h exp=00202423", mem_wdata); end
        n_tests++; if (mem_addr !== 2'd1) begin n_fail++; $display("FAIL stype_addr got=%0d exp=1", mem_addr); end
        pulse_ack();
        n_tests++; if (wr_count !== 3'd2) begin n_fail++; $display("FAIL stype_count got=%0d exp=2", wr_count); end
    endtask

    task automatic test_errors();
        drive_bundle(2'b00, 32'h0000_0800, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd0);
        n_tests++; if ({err_range, err_src, mem_we} !== 3'b100) begin n_fail++; $display("FAIL range_pulse got=%b exp=100", {err_range, err_src, mem_we}); end
        @(negedge clk);
        n_tests++; if ({err_range, mem_we} !== 2'b00) begin n_fail++; $display("FAIL range_one_cycle got=%b exp=00", {err_range, mem_we}); end
        n_tests++; if (mem_addr !== 2'd2) begin n_fail++; $display("FAIL range_addr got=%0d exp=2", mem_addr); end
        drive_bundle(2'b11, 32'h0000_0800, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd0);
        n_tests++; if ({err_range, err_src, mem_we} !== 3'b010) begin n_fail++; $display("FAIL src_pulse got=%b exp=010", {err_range, err_src, mem_we}); end
        @(negedge clk);
        n_tests++; if ({err_src, in_ready, wr_count} !== {2'b01, 3'd2}) begin n_fail++; $display("FAIL src_after got=%b exp=01010", {err_src, in_ready, wr_count}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w;
        exp_w = ref_pack(2'b00, 32'hFFFF_F9C0, 7'b0000011, 3'b010, 5'd7, 5'd3, 5'd0);
        drive_bundle(2'b00, 32'hFFFF_F9C0, 7'b0000011, 3'b010, 5'd7, 5'd3, 5'd0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({mem_we, in_ready, mem_addr, mem_wdata} !== {2'b10, 2'd2, exp_w}) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d we=%b rdy=%b addr=%0d data=%h exp we=1 rdy=0 addr=2 data=%h",
                         i, mem_we, in_ready, mem_addr, mem_wdata, exp_w);
            end
            @(negedge clk);
        end
        pulse_ack();
        n_tests++; if ({mem_we, in_ready, wr_count} !== {2'b01, 3'd3}) begin n_fail++; $display("FAIL bp_release got=%b exp=01011", {mem_we, in_ready, wr_count}); end
    endtask

    task automatic test_full_wrap();
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) begin
            drive_bundle(2'b00, 32'(i), 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0);
            n_tests++; if (mem_addr !== D'(i)) begin n_fail++; $display("FAIL full_addr i=%0d got=%0d exp=%0d", i, mem_addr, i); end
            pulse_ack();
        end
        n_tests++; if ({full, in_ready} !== 2'b10) begin n_fail++; $display("FAIL full_flags got=%b exp=10", {full, in_ready}); end
        n_tests++; if (wr_count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", wr_count); end
        n_tests++; if (mem_addr !== 2'd3) begin n_fail++; $display("FAIL full_addr_hold got=%0d exp=3", mem_addr); end
        drive_bundle(2'b00, 32'd5, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0);
        n_tests++; if ({mem_we, full, wr_count} !== {2'b01, 3'd4}) begin n_fail++; $display("FAIL full_reject got=%b exp=01100", {mem_we, full, wr_count}); end
        pulse_clear();
        n_tests++; if ({mem_addr, full, wr_count, in_ready} !== {2'd0, 1'b0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL full_clear addr=%0d full=%b cnt=%0d rdy=%b", mem_addr, full, wr_count, in_ready); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [1:0]  src;
        logic [31:0] v, exp_w;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  a_rd, a_rs1, a_rs2;
        int          cnt, nb, dly;
        for (int it = 0; it < 20; it++) begin
            pulse_clear();
            cnt = 0;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                src   = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) != 0) v = 32'($urandom_range(0, 4095)) - 32'd2048;
                else                           v = $urandom;
                opc   = 7'($urandom); f3 = 3'($urandom);
                a_rd  = 5'($urandom); a_rs1 = 5'($urandom); a_rs2 = 5'($urandom);
                if (cnt == DEPTH) begin
                    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_full_ready got=%b exp=0", in_ready); end
                    drive_bundle(src, v, opc, f3, a_rd, a_rs1, a_rs2);
                    n_tests++; if ({mem_we, full} !== 2'b01) begin n_fail++; $display("FAIL rnd_full_hold got=%b exp=01", {mem_we, full}); end
                end else begin
                    drive_bundle(src, v, opc, f3, a_rd, a_rs1, a_rs2);
                    if (src >= 2'd2) begin
                        n_tests++; if ({err_src, err_range, mem_we} !== 3'b100) begin n_fail++; $display("FAIL rnd_src src=%0d imm=%h got=%b exp=100", src, v, {err_src, err_range, mem_we}); end
                    end else if (!ref_fits12(v)) begin
                        n_tests++; if ({err_src, err_range, mem_we} !== 3'b010) begin n_fail++; $display("FAIL rnd_range imm=%h got=%b exp=010", v, {err_src, err_range, mem_we}); end
                    end else begin
                        exp_q.push_back(ref_pack(src, v, opc, f3, a_rd, a_rs1, a_rs2));
                        exp_w = exp_q.pop_front();
                        dly = $urandom_range(0, 3);
                        repeat (dly) @(negedge clk);
                        n_tests++;
                        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, D'(cnt % DEPTH), exp_w}) begin
                            n_fail++;
                            $display("FAIL rnd_write we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                                     mem_we, mem_addr, mem_wdata, cnt % DEPTH, exp_w);
                        end
                        pulse_ack();
                        cnt++;
                        n_tests++;
                        if ({wr_count, full, mem_addr} !== {3'(cnt), cnt == DEPTH, D'(cnt == DEPTH ? DEPTH - 1 : cnt)}) begin
                            n_fail++;
                            $display("FAIL rnd_after_ack cnt=%0d full=%b addr=%0d exp cnt=%0d", wr_count, full, mem_addr, cnt);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_abort_clear();
        apply_reset();
        drive_bundle(2'b00, 32'd100, 7'b0010011, 3'b000, 5'd4, 5'd4, 5'd0);
        clear = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        clear = 1'b0; mem_ack = 1'b0;
        n_tests++; if ({mem_we, wr_count, mem_addr} !== {1'b0, 3'd0, 2'd0}) begin n_fail++; $display("FAIL abort_clear we=%b cnt=%0d addr=%0d exp 0 0 0", mem_we, wr_count, mem_addr); end
    endtask

    task automatic test_abort_reset();
        drive_bundle(2'b00, 32'd1, 7'b0010011, 3'b000, 5'd4, 5'd4, 5'd0);
        pulse_ack();
        drive_bundle(2'b01, 32'hFFFF_FFF0, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd9);
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_rst_pre got=%b exp=1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({mem_we, full, err_range, err_src, in_ready} !== 5'b00001) begin n_fail++; $display("FAIL abort_rst_flags got=%b exp=00001", {mem_we, full, err_range, err_src, in_ready}); end
        n_tests++; if ({mem_addr, wr_count, mem_wdata} !== {2'd0, 3'd0, 32'h0}) begin n_fail++; $display("FAIL abort_rst_regs addr=%0d cnt=%0d data=%h exp 0 0 0", mem_addr, wr_count, mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        imm_src = '0; imm = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0;
        @(negedge clk);
        test_reset();
        test_itype();
        test_stype();
        test_errors();
        test_backpressure();
        test_full_wrap();
        test_random();
        test_abort_clear();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
